// File: rtl/imm_gen_pkg.sv
// Shared definitions for the RV32I immediate generator: opcode values,
// immediate format codes and the supported data width.
package imm_gen_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction: instruction word in, immediate value
// and format code out. With IMM_ZICSR_EN defined, the immediate CSR forms
// (SYSTEM opcode with funct3[2] set) yield the zero-extended zimm field;
// otherwise they decode as ordinary I-type immediates.
module imm_decode
  import imm_gen_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [31:0] o_imm,
  output logic [2:0]  o_type
);

  logic [6:0] w_opcode;
  logic [31:0] w_imm;
  imm_type_e w_type;

  assign w_opcode = i_instr[6:0];

  // Select the immediate layout from the opcode; bit 31 is always the sign source
  always_comb begin
    w_imm  = 32'h0;
    w_type = IMM_NONE;
    case (w_opcode)
      OP_IMM, OP_LOAD, OP_JALR: begin
        w_imm  = {{20{i_instr[31]}}, i_instr[31:20]};
        w_type = IMM_I;
      end
      OP_SYSTEM: begin
`ifdef IMM_ZICSR_EN
        if (i_instr[14]) begin
          w_imm  = {27'h0, i_instr[19:15]};
          w_type = IMM_Z;
        end else begin
          w_imm  = {{20{i_instr[31]}}, i_instr[31:20]};
          w_type = IMM_I;
        end
`else
        w_imm  = {{20{i_instr[31]}}, i_instr[31:20]};
        w_type = IMM_I;
`endif
      end
      OP_STORE: begin
        w_imm  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        w_type = IMM_S;
      end
      OP_BRANCH: begin
        w_imm  = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                  i_instr[30:25], i_instr[11:8], 1'b0};
        w_type = IMM_B;
      end
      OP_LUI, OP_AUIPC: begin
        w_imm  = {i_instr[31:12], 12'h0};
        w_type = IMM_U;
      end
      OP_JAL: begin
        w_imm  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                  i_instr[20], i_instr[30:21], 1'b0};
        w_type = IMM_J;
      end
      default: begin
        w_imm  = 32'h0;
        w_type = IMM_NONE;
      end
    endcase
  end

  assign o_imm  = w_imm;
  assign o_type = w_type;

endmodule

// File: rtl/immediate_generator.sv
// Decode-stage immediate generator: combinational decode followed by one
// output register stage. Optional macro IMM_ZICSR_EN enables the zimm
// format for immediate CSR instructions (handled inside imm_decode).
module immediate_generator
  import imm_gen_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] instr_in,
  output logic [XLEN-1:0] immediate_instr,
  output logic [2:0]      imm_type
);

  logic [31:0] w_imm;
  logic [2:0]  w_type;
  logic [31:0] r_imm;
  logic [2:0]  r_type;

  imm_decode u_imm_decode (
    .i_instr (instr_in),
    .o_imm   (w_imm),
    .o_type  (w_type)
  );

  // Capture a fresh decode every edge; reset wins over capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_imm  <= 32'h0;
      r_type <= IMM_NONE;
    end else begin
      r_imm  <= w_imm;
      r_type <= w_type;
    end
  end

  assign immediate_instr = r_imm;
  assign imm_type        = r_type;

endmodule

// File: tb/tb_immediate_generator.sv
// Directed testbench for immediate_generator. Expected values are hand
// computed from the RV32I encodings; the CSR-immediate expectation follows
// whether IMM_ZICSR_EN is defined for the build.
module tb_immediate_generator;
  import imm_gen_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_in;
  logic [31:0] immediate_instr;
  logic [2:0]  imm_type;

  int checks = 0;
  int errors = 0;

  immediate_generator dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instr_in        (instr_in),
    .immediate_instr (immediate_instr),
    .imm_type        (imm_type)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs away from the rising edge, then wait for the capture edge
  task automatic applyStimulus(input logic [31:0] instr, input logic rst);
    @(negedge clk);
    instr_in = instr;
    rst_n    = rst;
    @(posedge clk);
    #1;
  endtask

  // Compare registered outputs against hand-computed values
  task automatic checkOutput(input string tag, input logic [31:0] expImm,
                             input logic [2:0] expType);
    checks++;
    assert (immediate_instr === expImm) else begin
      errors++;
      $error("[TB] FAIL %s: immediate_instr observed %h expected %h",
             tag, immediate_instr, expImm);
    end
    checks++;
    assert (imm_type === expType) else begin
      errors++;
      $error("[TB] FAIL %s: imm_type observed %0d expected %0d",
             tag, imm_type, expType);
    end
  endtask

  // Linear sequence of directed steps
  initial begin
    logic [31:0] csrExpImm;
    logic [2:0]  csrExpType;
`ifdef IMM_ZICSR_EN
    csrExpImm  = 32'h00000005;
    csrExpType = IMM_Z;
`else
    csrExpImm  = 32'h00000000;
    csrExpType = IMM_I;
`endif

    rst_n    = 1'b0;
    instr_in = 32'hFFF10093;

    applyStimulus(32'hFFF10093, 1'b0);
    checkOutput("reset0", 32'h0, IMM_NONE);
    applyStimulus(32'h123450B7, 1'b0);
    checkOutput("reset1", 32'h0, IMM_NONE);

    applyStimulus(32'h003100B3, 1'b1);
    checkOutput("add", 32'h00000000, IMM_NONE);
    applyStimulus(32'h00210093, 1'b1);
    checkOutput("addi_2", 32'h00000002, IMM_I);
    applyStimulus(32'hFFF10093, 1'b1);
    checkOutput("addi_m1", 32'hFFFFFFFF, IMM_I);
    applyStimulus(32'hFFC12083, 1'b1);
    checkOutput("lw_m4", 32'hFFFFFFFC, IMM_I);
    applyStimulus(32'h008080E7, 1'b1);
    checkOutput("jalr_8", 32'h00000008, IMM_I);
    applyStimulus(32'h00112423, 1'b1);
    checkOutput("sw_8", 32'h00000008, IMM_S);
    applyStimulus(32'hFE112E23, 1'b1);
    checkOutput("sw_m4", 32'hFFFFFFFC, IMM_S);
    applyStimulus(32'h00208463, 1'b1);
    checkOutput("beq_p8", 32'h00000008, IMM_B);
    applyStimulus(32'hFE208EE3, 1'b1);
    checkOutput("beq_m4", 32'hFFFFFFFC, IMM_B);
    applyStimulus(32'h123450B7, 1'b1);
    checkOutput("lui", 32'h12345000, IMM_U);
    applyStimulus(32'hFFFFF097, 1'b1);
    checkOutput("auipc", 32'hFFFFF000, IMM_U);
    applyStimulus(32'h002000EF, 1'b1);
    checkOutput("jal_p2", 32'h00000002, IMM_J);
    applyStimulus(32'hFFDFF0EF, 1'b1);
    checkOutput("jal_m4", 32'hFFFFFFFC, IMM_J);
    applyStimulus(32'h0002D073, 1'b1);
    checkOutput("csrrwi", csrExpImm, csrExpType);
    applyStimulus(32'h30529073, 1'b1);
    checkOutput("csrrw", 32'h00000305, IMM_I);
    applyStimulus(32'h0FF0000F, 1'b1);
    checkOutput("fence", 32'h00000000, IMM_NONE);

    // Latency: a new word driven before the edge must not show up early
    @(negedge clk);
    instr_in = 32'h00210093;
    #1;
    checkOutput("hold_before_edge", 32'h00000000, IMM_NONE);
    @(posedge clk);
    #1;
    checkOutput("b2b_0", 32'h00000002, IMM_I);
    applyStimulus(32'h123450B7, 1'b1);
    checkOutput("b2b_1", 32'h12345000, IMM_U);
    applyStimulus(32'hFE208EE3, 1'b1);
    checkOutput("b2b_2", 32'hFFFFFFFC, IMM_B);

    // Reset mid-stream takes priority, then capture resumes on the first released edge
    applyStimulus(32'hFFF10093, 1'b0);
    checkOutput("reset_mid", 32'h0, IMM_NONE);
    applyStimulus(32'hFFF10093, 1'b1);
    checkOutput("after_reset", 32'hFFFFFFFF, IMM_I);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
